breath_mode_ctrl: RTL and testbench

- Mode sequencer for the touch-key breath-LED datapath.
- Owns the shared 2us/2ms/2s timebase and the single LED and beep outputs.
- Each accepted touch-key press advances the LED mode OFF -> BREATH -> ON -> BLINK -> OFF and sounds a short confirmation beep.
- Sits between the raw board pins (touch_key in; led and beep out) and the rest of the design.

---
 rtl/breath_mode_ctrl.sv | 179 +++++++++++++++++
 tb/tb_breath_mode_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/breath_mode_ctrl.sv
// Touch-key mode sequencer: OFF -> BREATH -> ON -> BLINK, shared 2us/2ms/2s timebase, LED and beep drive.
// Optional confirmation beep is built only when KEY_BEEP_EN is defined; otherwise beep is tied low.
module breath_mode_ctrl #(
  parameter int unsigned CNT_2US_MAX = 99,
  parameter int unsigned CNT_2MS_MAX = 999,
  parameter int unsigned CNT_2S_MAX  = 999,
  parameter int unsigned BEEP_TICKS  = 50,
  parameter int unsigned LOCK_TICKS  = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       touch_key,
  output logic       led,
  output logic       beep,
  output logic [1:0] mode
);

  localparam int unsigned US_W     = $clog2(CNT_2US_MAX + 1);
  localparam int unsigned MS_W     = $clog2(CNT_2MS_MAX + 1);
  localparam int unsigned S_W      = $clog2(CNT_2S_MAX + 1);
  localparam int unsigned TICK_MAX = (LOCK_TICKS > BEEP_TICKS) ? LOCK_TICKS : BEEP_TICKS;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BREATH = 2'd1,
    MODE_ON     = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic              key_s1_q, key_s1_d;
  logic              key_s2_q, key_s2_d;
  logic              key_dly_q, key_dly_d;
  logic [US_W-1:0]   cnt_2us_q, cnt_2us_d;
  logic [MS_W-1:0]   cnt_2ms_q, cnt_2ms_d;
  logic [S_W-1:0]    cnt_2s_q, cnt_2s_d;
  logic              dir_q, dir_d;
  logic              blink_q, blink_d;
  logic              lock_q, lock_d;
  logic [TICK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              led_q, led_d;
  logic              press_c, tick_2us_c, tick_2ms_c, tick_2s_c;

  // Next-state: synchronizer, timebase, lockout, mode FSM and LED pattern
  always_comb begin
    mode_d     = mode_q;
    key_s1_d   = touch_key;
    key_s2_d   = key_s1_q;
    key_dly_d  = key_s2_q;
    cnt_2us_d  = cnt_2us_q;
    cnt_2ms_d  = cnt_2ms_q;
    cnt_2s_d   = cnt_2s_q;
    dir_d      = dir_q;
    blink_d    = blink_q;
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    led_d      = 1'b0;

    press_c    = key_s2_q & ~key_dly_q & ~lock_q;
    tick_2us_c = (cnt_2us_q == US_W'(CNT_2US_MAX));
    tick_2ms_c = tick_2us_c & (cnt_2ms_q == MS_W'(CNT_2MS_MAX));
    tick_2s_c  = tick_2ms_c & (cnt_2s_q == S_W'(CNT_2S_MAX));

    cnt_2us_d = tick_2us_c ? '0 : cnt_2us_q + US_W'(1);
    if (tick_2us_c) cnt_2ms_d = tick_2ms_c ? '0 : cnt_2ms_q + MS_W'(1);
    if (tick_2ms_c) cnt_2s_d = tick_2s_c ? '0 : cnt_2s_q + S_W'(1);
    if (tick_2s_c) begin
      dir_d   = ~dir_q;
      blink_d = ~blink_q;
    end

    if (lock_q && tick_2ms_c) begin
      if (lock_cnt_q == TICK_W'(LOCK_TICKS - 1)) begin
        lock_d     = 1'b0;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + TICK_W'(1);
      end
    end

    case (mode_q)
      MODE_OFF:    led_d = 1'b0;
      MODE_BREATH: led_d = dir_q ? (cnt_2ms_q >= cnt_2s_q) : (cnt_2ms_q < cnt_2s_q);
      MODE_ON:     led_d = 1'b1;
      MODE_BLINK:  led_d = blink_q;
      default:     led_d = 1'b0;
    endcase

    // An accepted press restarts every phase and wins over a coincident tick_2s
    if (press_c) begin
      cnt_2us_d  = '0;
      cnt_2ms_d  = '0;
      cnt_2s_d   = '0;
      dir_d      = 1'b0;
      blink_d    = 1'b0;
      lock_d     = 1'b1;
      lock_cnt_d = '0;
      case (mode_q)
        MODE_OFF:    mode_d = MODE_BREATH;
        MODE_BREATH: mode_d = MODE_ON;
        MODE_ON:     mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_OFF;
        default:     mode_d = MODE_OFF;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q     <= MODE_OFF;
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_dly_q  <= 1'b0;
      cnt_2us_q  <= '0;
      cnt_2ms_q  <= '0;
      cnt_2s_q   <= '0;
      dir_q      <= 1'b0;
      blink_q    <= 1'b0;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      led_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_dly_q  <= key_dly_d;
      cnt_2us_q  <= cnt_2us_d;
      cnt_2ms_q  <= cnt_2ms_d;
      cnt_2s_q   <= cnt_2s_d;
      dir_q      <= dir_d;
      blink_q    <= blink_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      led_q      <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

`ifdef KEY_BEEP_EN
  logic              beep_q, beep_d;
  logic [TICK_W-1:0] beep_cnt_q, beep_cnt_d;

  // Beep runs for BEEP_TICKS 2ms ticks, restarted by every accepted press
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (beep_q && tick_2ms_c) begin
      if (beep_cnt_q == TICK_W'(BEEP_TICKS - 1)) begin
        beep_d     = 1'b0;
        beep_cnt_d = '0;
      end else begin
        beep_cnt_d = beep_cnt_q + TICK_W'(1);
      end
    end
    if (press_c) begin
      beep_d     = 1'b1;
      beep_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_breath_mode_ctrl.sv
// Bench for breath_mode_ctrl: directed and random key activity checked against a time-since-press model.
module tb_breath_mode_ctrl;

  localparam int unsigned P_US   = 2;
  localparam int unsigned P_MS   = 10;
  localparam int unsigned P_S    = 10;
  localparam int unsigned P_BEEP = 2;
  localparam int unsigned P_LOCK = 3;
  localparam int TPER = (P_US + 1) * (P_MS + 1);
  localparam int HALF = TPER * (P_S + 1);
  localparam int BIG  = 1 << 20;
`ifdef KEY_BEEP_EN
  localparam logic BEEP_EN = 1'b1;
`else
  localparam logic BEEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       touch_key = 1'b0;
  logic       led, beep;
  logic [1:0] mode;

  always #10 clk = ~clk;

  breath_mode_ctrl #(
    .CNT_2US_MAX(P_US), .CNT_2MS_MAX(P_MS), .CNT_2S_MAX(P_S),
    .BEEP_TICKS(P_BEEP), .LOCK_TICKS(P_LOCK)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .touch_key(touch_key),
    .led(led), .beep(beep), .mode(mode)
  );

  int   errors = 0;
  int   checks = 0;
  int   m_mode = 0;
  int   m_t = 0;
  int   m_since = BIG;
  logic m_led = 1'b0;
  bit   hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // LED level implied by mode and cycles elapsed since the mode started
  function automatic logic led_fn(input int md, input int t);
    int p2ms, p2s, half;
    p2ms = (t / (P_US + 1)) % (P_MS + 1);
    p2s  = (t / TPER) % (P_S + 1);
    half = (t / HALF) % 2;
    case (md)
      1:       return (half == 1) ? (p2ms >= p2s) : (p2ms < p2s);
      2:       return 1'b1;
      3:       return half[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input logic key, input logic rst);
    bit locked, pressed;
    if (rst) begin
      m_mode = 0; m_t = 0; m_since = BIG; m_led = 1'b0;
      hist = '{0, 0, 0};
    end else begin
      m_led   = led_fn(m_mode, m_t);
      locked  = (m_since < int'(P_LOCK) * TPER);
      pressed = hist[1] && !hist[2] && !locked;
      if (pressed) begin
        m_mode = (m_mode + 1) % 4; m_t = 0; m_since = 0;
      end else begin
        m_t++;
        if (m_since < BIG) m_since++;
      end
      hist.push_front(key);
      void'(hist.pop_back());
    end
  endtask

  function automatic logic exp_beep();
    return BEEP_EN && (m_since < int'(P_BEEP) * TPER);
  endfunction

  task automatic cyc(input logic key, input logic rst);
    @(negedge clk);
    touch_key = key;
    sys_rst   = rst;
    @(posedge clk);
    model_edge(key, rst);
    #1;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("led", 32'(led), 32'(m_led));
    chk("beep", 32'(beep), 32'(exp_beep()));
  endtask

  task automatic press_key();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int cnt, cnt2, changes;
    logic [1:0] prev;
    logic key;
    int hold;
    hist = '{0, 0, 0};

    for (int i = 0; i < 10; i++) cyc(logic'(i % 2), 1'b1);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_beep", 32'(beep), 0);
    gap(5);

    // First press: effect lands on the third edge counting the sampling edge
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("e1_mode", 32'(mode), 0);
    cyc(1'b0, 1'b0);
    chk("e2_mode", 32'(mode), 1);
    chk("e2_beep", 32'(beep), 32'(BEEP_EN));
    cnt = beep ? 1 : 0;
    for (int k = 1; k < 120; k++) begin
      cyc((k == 50) ? 1'b1 : 1'b0, 1'b0);
      if (beep) cnt++;
    end
    chk("lockout_ignored", 32'(mode), 1);
    chk("beep_len", 32'(cnt), BEEP_EN ? 32'(66) : 32'(0));
    press_key();
    chk("second_press_mode", 32'(mode), 2);
    cyc(1'b0, 1'b0);
    chk("on_led", 32'(led), 1);

    gap(100); press_key(); chk("seq_blink", 32'(mode), 3);
    gap(100); press_key(); chk("seq_off", 32'(mode), 0);
    gap(100); press_key(); chk("seq_breath", 32'(mode), 1);

    // Breath: inhale windows give 0..10 of 11 slots, exhale the complement
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 2 * HALF; k++) begin
      cyc(1'b0, 1'b0);
      if (led) begin
        cnt++;
        if (k < HALF) cnt2++;
      end
    end
    chk("breath_inhale_on", 32'(cnt2), 165);
    chk("breath_total_on", 32'(cnt), 363);
    chk("breath_mode_held", 32'(mode), 1);

    press_key(); chk("seq2_on", 32'(mode), 2);
    gap(100); press_key(); chk("seq2_blink", 32'(mode), 3);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 2 * HALF; k++) begin
      cyc(1'b0, 1'b0);
      if (led) begin
        if (k < HALF) cnt++;
        else cnt2++;
      end
    end
    chk("blink_first_half", 32'(cnt), 0);
    chk("blink_second_half", 32'(cnt2), 363);
    press_key(); chk("seq2_off", 32'(mode), 0);

    gap(100);
    changes = 0;
    prev = mode;
    for (int k = 0; k < 2000; k++) begin
      cyc(1'b1, 1'b0);
      if (mode != prev) changes++;
      prev = mode;
    end
    chk("hold_changes", 32'(changes), 1);
    chk("hold_mode", 32'(mode), 1);
    gap(100);

    press_key();
    chk("mid_beep_mode", 32'(mode), 2);
    gap(20);
    chk("mid_beep_on", 32'(beep), 32'(BEEP_EN));
    cyc(1'b0, 1'b1);
    chk("mid_rst_beep", 32'(beep), 0);
    chk("mid_rst_mode", 32'(mode), 0);
    gap(5);
    press_key();
    chk("post_rst_press", 32'(mode), 1);

    key = 1'b0;
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        key  = ~key;
        hold = int'($urandom_range(1, 150));
      end
      hold--;
      cyc(key, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
